// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution MAC sequencer.
package conv_pkg;

   localparam int unsigned KSIZE_D   = 3;
   localparam int unsigned IMG_W_D   = 8;
   localparam int unsigned IMG_H_D   = 8;
   localparam int unsigned MAC_LAT_D = 1;
   localparam int unsigned OUT_W_D   = IMG_W_D - KSIZE_D + 1;
   localparam int unsigned OUT_H_D   = IMG_H_D - KSIZE_D + 1;
   localparam int unsigned TAPS_D    = KSIZE_D * KSIZE_D;
   localparam int unsigned SUM_W     = 32;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFetch,
      StDrain,
      StOutput
   } conv_state_e;

endpackage

// File: rtl/conv_window_addr_gen.sv
// Window (row/col) and tap (kr/kc) counters with pixel/weight address arithmetic.
module conv_window_addr_gen
   import conv_pkg::*;
#(
   parameter int unsigned KSIZE  = KSIZE_D,
   parameter int unsigned IMG_W  = IMG_W_D,
   parameter int unsigned IMG_H  = IMG_H_D,
   parameter int unsigned PIX_AW = 8,
   parameter int unsigned WT_AW  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance_tap,
   input  logic              advance_window,
   output logic [PIX_AW-1:0] pix_addr,
   output logic [WT_AW-1:0]  wt_addr,
   output logic [7:0]        row,
   output logic [7:0]        col,
   output logic              last_tap,
   output logic              last_window
);

   localparam int unsigned OUT_W = IMG_W - KSIZE + 1;
   localparam int unsigned OUT_H = IMG_H - KSIZE + 1;

   logic [7:0] row_q, col_q, kr_q, kc_q;

   assign last_tap    = (kr_q == 8'(KSIZE - 1)) && (kc_q == 8'(KSIZE - 1));
   assign last_window = (row_q == 8'(OUT_H - 1)) && (col_q == 8'(OUT_W - 1));

   assign pix_addr = PIX_AW'((32'(row_q) + 32'(kr_q)) * 32'(IMG_W) + 32'(col_q) + 32'(kc_q));
   assign wt_addr  = WT_AW'(32'(kr_q) * 32'(KSIZE) + 32'(kc_q));
   assign row      = row_q;
   assign col      = col_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         row_q <= '0;
         col_q <= '0;
         kr_q  <= '0;
         kc_q  <= '0;
      end else begin
         if (advance_tap) begin
            if (kc_q == 8'(KSIZE - 1)) begin
               kc_q <= '0;
               kr_q <= last_tap ? 8'd0 : kr_q + 8'd1;
            end else begin
               kc_q <= kc_q + 8'd1;
            end
         end
         // Wrapping to 0 after the last window leaves the counters ready for the next image.
         if (advance_window) begin
            if (last_window) begin
               row_q <= '0;
               col_q <= '0;
            end else if (col_q == 8'(OUT_W - 1)) begin
               col_q <= '0;
               row_q <= row_q + 8'd1;
            end else begin
               col_q <= col_q + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Drives a MAC through a stride-1 unpadded KSIZE x KSIZE convolution and streams window sums.
module conv_mac_sequencer
   import conv_pkg::*;
#(
   parameter int unsigned KSIZE   = KSIZE_D,
   parameter int unsigned IMG_W   = IMG_W_D,
   parameter int unsigned IMG_H   = IMG_H_D,
   parameter int unsigned PIX_AW  = 8,
   parameter int unsigned WT_AW   = 4,
   parameter int unsigned MAC_LAT = MAC_LAT_D
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [PIX_AW-1:0] pix_addr,
   input  logic [7:0]        pix_data,
   output logic [WT_AW-1:0]  wt_addr,
   input  logic [7:0]        wt_data,
   output logic [7:0]        mac_x,
   output logic [7:0]        mac_y,
   output logic              mac_accum_reset,
   input  logic [SUM_W-1:0]  mac_sum,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out_data,
   output logic [7:0]        out_row,
   output logic [7:0]        out_col
);

   // Last operand cycle plus the accumulator's own latency.
   localparam int unsigned DRAIN_CYCLES = 1 + MAC_LAT;

   conv_state_e state_q, state_d;

   logic [3:0]        drain_q;
   logic              tap_valid_q;
   logic [PIX_AW-1:0] pix_addr_q;
   logic [WT_AW-1:0]  wt_addr_q;
   logic [SUM_W-1:0]  out_data_q;
   logic              done_q, done_d;

   logic              clear_cnt, advance_tap, advance_window, capture;
   logic              last_tap, last_window;
   logic [PIX_AW-1:0] gen_pix_addr;
   logic [WT_AW-1:0]  gen_wt_addr;
   logic [7:0]        gen_row, gen_col;

   conv_window_addr_gen #(
      .KSIZE  (KSIZE),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .PIX_AW (PIX_AW),
      .WT_AW  (WT_AW)
   ) u_addr_gen (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear_cnt),
      .advance_tap    (advance_tap),
      .advance_window (advance_window),
      .pix_addr       (gen_pix_addr),
      .wt_addr        (gen_wt_addr),
      .row            (gen_row),
      .col            (gen_col),
      .last_tap       (last_tap),
      .last_window    (last_window)
   );

   always_comb begin
      state_d        = state_q;
      clear_cnt      = 1'b0;
      advance_tap    = 1'b0;
      advance_window = 1'b0;
      capture        = 1'b0;
      done_d         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               clear_cnt = 1'b1;
               state_d   = StClear;
            end
         end
         StClear: state_d = StFetch;
         StFetch: begin
            advance_tap = 1'b1;
            if (last_tap) state_d = StDrain;
         end
         StDrain: begin
            if (drain_q == 4'(DRAIN_CYCLES - 1)) begin
               capture = 1'b1;
               state_d = StOutput;
            end
         end
         StOutput: begin
            if (out_ready) begin
               advance_window = 1'b1;
               if (last_window) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StClear;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         drain_q     <= '0;
         tap_valid_q <= 1'b0;
         pix_addr_q  <= '0;
         wt_addr_q   <= '0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_q     <= (state_q == StDrain) ? drain_q + 4'd1 : 4'd0;
         tap_valid_q <= (state_q == StFetch);
         done_q      <= done_d;
         if (state_q == StFetch) begin
            pix_addr_q <= gen_pix_addr;
            wt_addr_q  <= gen_wt_addr;
         end
         if (capture) out_data_q <= mac_sum;
      end
   end

   // Addresses come straight from the counters while fetching and hold the last tap otherwise.
   assign pix_addr        = (state_q == StFetch) ? gen_pix_addr : pix_addr_q;
   assign wt_addr         = (state_q == StFetch) ? gen_wt_addr : wt_addr_q;
   assign mac_x           = tap_valid_q ? pix_data : 8'd0;
   assign mac_y           = tap_valid_q ? wt_data : 8'd0;
   assign mac_accum_reset = reset || (state_q == StClear);
   assign busy            = (state_q != StIdle);
   assign done            = done_q;
   assign out_valid       = (state_q == StOutput);
   assign out_data        = out_data_q;
   assign out_row         = gen_row;
   assign out_col         = gen_col;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench: sequencer plus behavioural sign-magnitude MAC and pixel/weight memories.
module tb_conv_mac_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, out_ready;
   logic        busy, done, mac_accum_reset, out_valid;
   logic [7:0]  pix_addr;
   logic [3:0]  wt_addr;
   logic [7:0]  pix_data, wt_data, mac_x, mac_y, out_row, out_col;
   logic [31:0] mac_sum, out_data;

   logic signed [7:0] pmem [256];
   logic signed [7:0] wmem [16];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int done_cnt = 0;
   int hs_cnt = 0;
   int t_start;
   logic [31:0] first_data, last_data;

   always #5 clk = ~clk;

   conv_mac_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .pix_addr        (pix_addr),
      .pix_data        (pix_data),
      .wt_addr         (wt_addr),
      .wt_data         (wt_data),
      .mac_x           (mac_x),
      .mac_y           (mac_y),
      .mac_accum_reset (mac_accum_reset),
      .mac_sum         (mac_sum),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_row         (out_row),
      .out_col         (out_col)
   );

   always_ff @(posedge clk) begin
      pix_data <= pmem[pix_addr];
      wt_data  <= wmem[wt_addr];
   end

   // Sign-magnitude multiplier feeding a 32-bit accumulator that adds on every edge.
   logic [7:0]  mag_x, mag_y;
   logic [15:0] mag_p;
   logic [31:0] prod, acc;
   always_comb begin
      mag_x = mac_x[7] ? 8'(-mac_x) : mac_x;
      mag_y = mac_y[7] ? 8'(-mac_y) : mac_y;
      mag_p = 16'(mag_x) * 16'(mag_y);
      prod  = (mac_x[7] ^ mac_y[7]) ? -{16'h0, mag_p} : {16'h0, mag_p};
   end
   always_ff @(posedge clk) begin
      if (mac_accum_reset) acc <= '0;
      else acc <= acc + prod;
   end
   assign mac_sum = acc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [31:0] model(input int r, input int c);
      int s = 0;
      for (int kr = 0; kr < 3; kr++)
         for (int kc = 0; kc < 3; kc++)
            s += int'(pmem[(r + kr) * 8 + c + kc]) * int'(wmem[kr * 3 + kc]);
      return 32'(s);
   endfunction

   task automatic load(input int mode);
      for (int i = 0; i < 256; i++)
         case (mode)
            0: pmem[i] = 8'sd1;
            1: pmem[i] = 8'(i);
            2: pmem[i] = 8'sd2;
            default: pmem[i] = -8'sd128;
         endcase
      for (int i = 0; i < 16; i++)
         case (mode)
            0: wmem[i] = 8'sd1;
            1: wmem[i] = (i == 4) ? 8'sd1 : 8'sd0;
            2: wmem[i] = -8'sd1;
            default: wmem[i] = -8'sd128;
         endcase
   endtask

   task automatic check_idle(input string tag, input logic exp_acc_rst);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"}, out_data, 32'd0);
      check({tag, "_paddr"}, 32'(pix_addr), 32'd0);
      check({tag, "_waddr"}, 32'(wt_addr), 32'd0);
      check({tag, "_macx"}, 32'(mac_x), 32'd0);
      check({tag, "_macy"}, 32'(mac_y), 32'd0);
      check({tag, "_row"}, 32'(out_row), 32'd0);
      check({tag, "_col"}, 32'(out_col), 32'd0);
      check({tag, "_accrst"}, 32'(mac_accum_reset), 32'(exp_acc_rst));
   endtask

   task automatic do_start();
      @(negedge clk);
      start   = 1'b1;
      t_start = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Collects all 36 windows; optional stall on window 0 and stray start during one window.
   task automatic collect(input string tag, input int stall, input int extra_start_at,
                          input bit timing);
      int t_prev = t_start;
      for (int w = 0; w < 36; w++) begin
         int n = 0;
         while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
         end
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         if (timing) check({tag, "_spacing"}, 32'(cyc - t_prev), 32'd13);
         t_prev = cyc;
         check({tag, "_data"}, out_data, model(w / 6, w % 6));
         check({tag, "_row"}, 32'(out_row), 32'(w / 6));
         check({tag, "_col"}, 32'(out_col), 32'(w % 6));
         if (w == 0) first_data = out_data;
         if (w == 35) last_data = out_data;
         if (w == 0 && stall > 0) begin
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
               check({tag, "_stall_data"}, out_data, first_data);
               check({tag, "_stall_row"}, 32'(out_row), 32'd0);
               check({tag, "_stall_col"}, 32'(out_col), 32'd0);
               check({tag, "_stall_accrst"}, 32'(mac_accum_reset), 32'd0);
            end
            out_ready = 1'b1;
         end
         if (w == extra_start_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic after_run(input string tag, input int done_before);
      repeat (3) @(negedge clk);
      check({tag, "_done_once"}, 32'(done_cnt), 32'(done_before + 1));
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int d0, h0, n;
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      load(0);
      repeat (3) @(negedge clk);
      check_idle("rst", 1'b1);
      reset = 1'b0;
      @(negedge clk);
      check_idle("idle", 1'b0);

      // Ones image with ones kernel: every window sums to 9, 13 cycles apart.
      d0 = done_cnt;
      do_start();
      collect("ones", 0, -1, 1'b1);
      check("ones_first", first_data, 32'd9);
      check("ones_last", last_data, 32'd9);
      after_run("ones", d0);

      // Address-valued pixels with identity kernel pick the window centre.
      load(1);
      d0 = done_cnt;
      do_start();
      collect("ident", 0, -1, 1'b1);
      check("ident_first", first_data, 32'd9);
      check("ident_last", last_data, 32'd54);
      after_run("ident", d0);

      load(2);
      d0 = done_cnt;
      do_start();
      collect("neg", 0, -1, 1'b1);
      check("neg_last", last_data, 32'hFFFF_FFEE);
      after_run("neg", d0);

      load(3);
      d0 = done_cnt;
      do_start();
      collect("fullrange", 0, -1, 1'b1);
      check("fullrange_last", last_data, 32'd147456);
      after_run("fullrange", d0);

      // Backpressure on the first window.
      load(1);
      out_ready = 1'b0;
      d0 = done_cnt;
      do_start();
      collect("stall", 5, -1, 1'b0);
      after_run("stall", d0);

      // A start during a run must be ignored.
      d0 = done_cnt;
      h0 = hs_cnt;
      do_start();
      collect("restart", 0, 10, 1'b1);
      after_run("restart", d0);
      check("restart_hs", 32'(hs_cnt - h0), 32'd36);

      // Reset while fetching window 3, with start asserted alongside it.
      d0 = done_cnt;
      h0 = hs_cnt;
      do_start();
      n = 0;
      while (hs_cnt < h0 + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_hs", 32'(hs_cnt), 32'(h0 + 2));
      repeat (3) @(negedge clk);
      check("abort_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check_idle("abort", 1'b1);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("abort_busy_post", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'(d0));
      check("abort_no_valid", 32'(hs_cnt), 32'(h0 + 2));
      do_start();
      collect("rerun", 0, -1, 1'b1);
      after_run("rerun", d0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/conv_mac_sequencer.md
Name: conv_mac_sequencer

Overview:
Sequences one signed 8x8 multiply-accumulate datapath (sign-magnitude multiplier feeding a 32-bit accumulator) through a stride-1, unpadded KSIZE x KSIZE convolution over an IMG_W x IMG_H 8-bit image.
- Generates pixel and weight memory addresses.
- Feeds operand pairs to the MAC.
- Clears the accumulator between output windows.
- Hands each finished 32-bit sum downstream over a valid/ready interface.
- Sits between the image/kernel memories and the MAC.

Parameters:
KSIZE, 3, kernel edge length (taps per window = KSIZE*KSIZE)
IMG_W, 8, image width in pixels
IMG_H, 8, image height in pixels
PIX_AW, 8, pixel memory address width (must hold IMG_W*IMG_H-1)
WT_AW, 4, weight memory address width (must hold KSIZE*KSIZE-1)
MAC_LAT, 1, clock edges from operands at MAC input to sum visible on mac_sum

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to convolve the full image; ignored unless IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final output handshake
pix_addr  out  PIX_AW  pixel memory read address
pix_data  in  8  signed pixel; valid one cycle after pix_addr
wt_addr  out  WT_AW  weight memory read address
wt_data  in  8  signed weight; valid one cycle after wt_addr
mac_x  out  8  MAC operand x
mac_y  out  8  MAC operand y
mac_accum_reset  out  1  synchronous clear of MAC accumulator
mac_sum  in  32  MAC accumulator value, two's complement
out_valid  out  1  out_data holds a finished window sum
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  32  window sum
out_row  out  8  output row index of out_data
out_col  out  8  output column index of out_data

Behaviour:
Reset values:
- All outputs 0, except mac_accum_reset = 1 while reset is high.
- State goes to IDLE and all counters clear.
- Reset mid-window aborts: no out_valid and no done is produced for the aborted run.

MAC contract:
- The accumulator adds on every edge and has no enable.
- mac_x and mac_y are forced to 0 on any cycle without a valid tap, so the product is 0.

Output geometry:
- OUT_W = IMG_W-KSIZE+1 and OUT_H = IMG_H-KSIZE+1.
- Windows are produced in raster order: col is the inner loop, row the outer loop.

Per-window tap addressing:
- Tap (kr,kc) is visited kr-major.
- pix_addr = (row+kr)*IMG_W + col+kc.
- wt_addr = kr*KSIZE + kc.

FSM states and transitions:
- IDLE: waits for start; then row=col=0 and go to CLEAR.
- CLEAR: 1 cycle with mac_accum_reset=1 and operands 0; then FETCH.
- FETCH: KSIZE*KSIZE cycles, one tap address issued per cycle.
  - A one-cycle-delayed tap_valid passes pix_data/wt_data straight to mac_x/mac_y in the following cycle.
  - After the last tap, go to DRAIN.
- DRAIN: 1+MAC_LAT cycles (last operand cycle plus accumulator latency); then register mac_sum into out_data and go to OUTPUT.
- OUTPUT: out_valid=1; out_data, out_row and out_col are held stable until out_ready.
  - On handshake: if this was the last window (row=OUT_H-1, col=OUT_W-1), pulse done and go to IDLE.
  - Otherwise advance col (wrap to 0 and increment row at OUT_W-1) and go to CLEAR.

Timing and conditions:
- Latency with out_ready held high: 1 + KSIZE^2 + 1 + MAC_LAT + 1 cycles per window; 13 for the defaults.
- start while busy: ignored.
- start and reset in the same cycle: reset wins.
- Address outputs hold their last value outside FETCH; operands are 0 outside tap-valid cycles.
- out_data passes mac_sum unmodified. Full-range products (e.g. -128*-128 = +16384) rely on the MAC's 32-bit width; this block does no saturation.

Decomposition:
- Shared package conv_pkg holds:
  - the FSM state enum (IDLE, CLEAR, FETCH, DRAIN, OUTPUT);
  - the KSIZE/IMG_W/IMG_H defaults;
  - the derived OUT_W, OUT_H and TAPS constants;
  - MAC_LAT;
  - the 32-bit sum width constant.
- One sub-module, conv_window_addr_gen, holds the row/col/kr/kc counters and address arithmetic. It has advance_tap/advance_window inputs and last_tap/last_window flags.
- The FSM, operand masking and output register stay in conv_mac_sequencer.
- The bench instantiates this block with the real MAC.

Test Plan:
- All pixels=1, all weights=1, out_ready=1, start pulse -> 36 outputs, each out_data=9, (row,col) from (0,0) to (5,5) in raster order, 13 cycles apart; exactly one done pulse.
- Pixel value = its address (0..63), identity kernel (center weight 1, others 0) -> out_data at (r,c) = (r+1)*8 + c+1; first output 9, last 54.
- All pixels=2, all weights=-1 -> every out_data = 32'hFFFF_FFEE (-18); all pixels=-128, weights=-128 -> 147456.
- out_ready low for 5 cycles at the first window -> out_valid stays high; out_data/out_row/out_col are stable; no new mac_accum_reset until the handshake.
- Reset asserted during FETCH of window 3 -> next cycle all outputs 0, busy=0, no done. A new start then reproduces the full 36-output sequence from (0,0).
- start pulsed again while busy -> no effect on sequence or count; done fires once.
